rc_mesh_adaptive: RTL
=====================

Name: rc_mesh_adaptive

Overview:
Generic five-port routing-computation stage for any router in a MESH_X x MESH_Y mesh; router position is set by parameters, not by hand-specialised modules.
Per input port it decodes the head flit, picks a minimal output direction and holds it for the whole packet (wormhole route lock). Adaptive choice between productive directions uses downstream pressure.
Each port has a one-stage valid/ready output register feeding the switch allocator.

Parameters:
DEPTH, 8, downstream buffer depth; pressure >= DEPTH means full
WIDTH, 3, pressure inputs are WIDTH+1 bits
DATASIZE, 40, flit width
MESH_X, 4, mesh columns
MESH_Y, 4, mesh rows
COORD_W, 2, coordinate field width
X_COORD, 1, this router's column
Y_COORD, 1, this router's row

Ports:
rc_clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
data_in  in  5*DATASIZE  port p at [p*DATASIZE +: DATASIZE]; p: 0=N, 1=E, 2=W, 3=S, 4=L
valid_in  in  5  flit valid per port
ready_out  out  5  per-port accept to upstream buffer
N_pressure_in, E_pressure_in, W_pressure_in, S_pressure_in  in  WIDTH+1 each  downstream occupancy, unsigned
data_out  out  5*DATASIZE  registered flit per port
direction_out  out  25  per port, 5-bit one-hot at [p*5 +: 5]; bit0=N, 1=E, 2=W, 3=S, 4=L; 0 = none
valid_out  out  5  registered flit valid
ready_in  in  5  switch allocator accepts valid_out
rc_err  out  5  one-cycle protocol-error pulse per port

Behaviour:
- Clock and reset: one clock, rc_clk. Reset is asynchronous and active-low on rst_n.
- Reset values: valid_out=0, data_out=0, direction_out=0, rc_err=0, all ports in state IDLE. Inputs are ignored while rst_n is low.
- Flit type in [DATASIZE-1:DATASIZE-2]: 10 head, 00 body, 01 tail, 11 single.
- dest_x = [DATASIZE-3 -: COORD_W]; dest_y = the next COORD_W bits below dest_x.
- Axes: X increases toward E, Y increases toward S.
- Handshake, per port independent: ready_out[p] = ~valid_out[p] | ready_in[p] (combinational).
- Accept when valid_in & ready_out. On accept, data_out, direction_out and valid_out load next cycle (latency 1).
- If valid_out=1 and ready_in=0, outputs hold stable. A simultaneous drain and accept gives full throughput.
- Route compute for head or single flits:
  - dx = dest_x vs X_COORD; dy = dest_y vs Y_COORD.
  - Both equal -> L, including L->L loopback.
  - Only dx nonzero -> E if dest_x > X_COORD, else W.
  - Only dy nonzero -> S if dest_y > Y_COORD, else N.
  - Both nonzero -> compare the pressures of the X and Y productive directions (adaptive rule below).
- Adaptive rule: pick the lower pressure; tie -> X direction. Pressures are sampled in the accept cycle only.
- Minimal routing never selects an off-mesh direction.
- Destination out of range (dest_x >= MESH_X or dest_y >= MESH_Y) -> route L and pulse rc_err.
- Per-port FSM, IDLE/LOCKED:
  - IDLE + head: compute route, store locked_dir, go LOCKED.
  - IDLE + single: compute route, stay IDLE.
  - IDLE + body/tail: route L, pulse rc_err, stay IDLE.
  - LOCKED + body: use locked_dir, stay LOCKED.
  - LOCKED + tail: use locked_dir, go IDLE.
  - LOCKED + head or single: re-route as new, pulse rc_err; next state follows the new flit's type.
- Transitions occur only on accept. Stalls never change the FSM state.
- Reset mid-packet: asynchronously clears to IDLE. Any partially forwarded packet is dropped; upstream must also reset.
- Data passes through unmodified.

Optional Feature:
RC_ADAPTIVE_EN
- Defined: pressure-based selection between productive directions, as in Behaviour.
- Undefined: deterministic XY routing. X is resolved first whenever dx is nonzero; pressure inputs are unused.

Test Plan:
- Setup for all scenarios: X_COORD=1, Y_COORD=1, 4x4 mesh.
- Reset: hold rst_n=0 then release -> valid_out=0, direction_out=0, rc_err=0, ready_out=5'b11111.
- Single on L, dest (3,1), ready_in all 1 -> next cycle valid_out[4]=1, direction_out[24:20]=00010 (E), data_out equals data_in.
- Single on L, dest (1,1) -> direction_out[24:20]=10000 (L).
- Single on W, dest (3,3), E_pressure=5, S_pressure=2 -> S (01000).
- Same flit with E=3, S=3 -> E (00010).
- Same flit, built without RC_ADAPTIVE_EN -> E in both cases.
- Head on N, dest (0,1) -> W (00100). Swap pressures, then send body and tail -> both W. A following single to (1,3) -> S, confirming the port returned to IDLE.
- Backpressure on E: valid_out[1]=1 with ready_in[1]=0 for 3 cycles -> ready_out[1]=0, outputs stable.
- Raise ready_in[1] with valid_in[1]=1 -> new flit accepted that cycle, output next cycle, no bubble.
- Body flit on S while IDLE -> direction L (10000), rc_err[3]=1 for exactly one cycle.
- Head with dest_x=3, MESH_X=3 -> L plus rc_err pulse.

Source files
------------

// File: rtl/rc_mesh_adaptive.sv
// Five-port routing-computation stage with per-port wormhole route lock and a registered valid/ready output.
// Build option: define RC_ADAPTIVE_EN for pressure-based choice between productive directions (default: XY).
module rc_mesh_adaptive #(
    parameter int DEPTH    = 8,
    parameter int WIDTH    = 3,
    parameter int DATASIZE = 40,
    parameter int MESH_X   = 4,
    parameter int MESH_Y   = 4,
    parameter int COORD_W  = 2,
    parameter int X_COORD  = 1,
    parameter int Y_COORD  = 1
) (
    input  logic                  rc_clk,
    input  logic                  rst_n,
    input  logic [5*DATASIZE-1:0] data_in,
    input  logic [4:0]            valid_in,
    output logic [4:0]            ready_out,
    input  logic [WIDTH:0]        N_pressure_in,
    input  logic [WIDTH:0]        E_pressure_in,
    input  logic [WIDTH:0]        W_pressure_in,
    input  logic [WIDTH:0]        S_pressure_in,
    output logic [5*DATASIZE-1:0] data_out,
    output logic [24:0]           direction_out,
    output logic [4:0]            valid_out,
    input  logic [4:0]            ready_in,
    output logic [4:0]            rc_err
);

    localparam logic [4:0] DIR_N = 5'b00001;
    localparam logic [4:0] DIR_E = 5'b00010;
    localparam logic [4:0] DIR_W = 5'b00100;
    localparam logic [4:0] DIR_S = 5'b01000;
    localparam logic [4:0] DIR_L = 5'b10000;

    localparam logic [1:0] T_HEAD   = 2'b10;
    localparam logic [1:0] T_BODY   = 2'b00;
    localparam logic [1:0] T_TAIL   = 2'b01;
    localparam logic [1:0] T_SINGLE = 2'b11;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_LOCKED = 1'b1
    } state_e;

    state_e                state_q    [5];
    state_e                state_d    [5];
    logic [4:0]            lock_dir_q [5];
    logic [4:0]            lock_dir_d [5];
    logic [5*DATASIZE-1:0] data_q, data_d;
    logic [24:0]           dir_q, dir_d;
    logic [4:0]            valid_q, valid_d;
    logic [4:0]            err_q, err_d;

    logic [1:0]            ftype_s  [5];
    logic [COORD_W-1:0]    dest_x_s [5];
    logic [COORD_W-1:0]    dest_y_s [5];
    logic [4:0]            x_dir_s  [5];
    logic [4:0]            y_dir_s  [5];
    logic [4:0]            rt_dir_s [5];
    logic [4:0]            rt_err_s;
    logic [4:0]            accept_s;

`ifdef RC_ADAPTIVE_EN
    logic [WIDTH:0]        px_s [5];
    logic [WIDTH:0]        py_s [5];

    // Anything at or above DEPTH is equally full, so clamp before comparing.
    function automatic logic [WIDTH:0] sat_f(input logic [WIDTH:0] p);
        logic [WIDTH:0] r;
        if (int'(p) >= DEPTH) begin
            r = (WIDTH+1)'(DEPTH);
        end else begin
            r = p;
        end
        return r;
    endfunction
`else
    logic unused_pressure_s;
    assign unused_pressure_s = ^{N_pressure_in, E_pressure_in, W_pressure_in, S_pressure_in, (DEPTH > 32'sd0)};
`endif

    assign ready_out     = ~valid_q | ready_in;
    assign accept_s      = valid_in & ready_out;
    assign data_out      = data_q;
    assign direction_out = dir_q;
    assign valid_out     = valid_q;
    assign rc_err        = err_q;

    // Decode each port's flit and compute its minimal route.
    always_comb begin
        for (int p = 0; p < 5; p++) begin
            ftype_s[p]  = data_in[p*DATASIZE + DATASIZE-1 -: 2];
            dest_x_s[p] = data_in[p*DATASIZE + DATASIZE-3 -: COORD_W];
            dest_y_s[p] = data_in[p*DATASIZE + DATASIZE-3-COORD_W -: COORD_W];
            x_dir_s[p]  = (int'(dest_x_s[p]) > X_COORD) ? DIR_E : DIR_W;
            y_dir_s[p]  = (int'(dest_y_s[p]) > Y_COORD) ? DIR_S : DIR_N;
`ifdef RC_ADAPTIVE_EN
            px_s[p]     = (x_dir_s[p] == DIR_E) ? E_pressure_in : W_pressure_in;
            py_s[p]     = (y_dir_s[p] == DIR_S) ? S_pressure_in : N_pressure_in;
`endif
            rt_err_s[p] = 1'b0;
            if ((int'(dest_x_s[p]) >= MESH_X) || (int'(dest_y_s[p]) >= MESH_Y)) begin
                rt_dir_s[p] = DIR_L;
                rt_err_s[p] = 1'b1;
            end else if ((int'(dest_x_s[p]) == X_COORD) && (int'(dest_y_s[p]) == Y_COORD)) begin
                rt_dir_s[p] = DIR_L;
            end else if (int'(dest_y_s[p]) == Y_COORD) begin
                rt_dir_s[p] = x_dir_s[p];
            end else if (int'(dest_x_s[p]) == X_COORD) begin
                rt_dir_s[p] = y_dir_s[p];
            end else begin
`ifdef RC_ADAPTIVE_EN
                rt_dir_s[p] = (sat_f(py_s[p]) < sat_f(px_s[p])) ? y_dir_s[p] : x_dir_s[p];
`else
                rt_dir_s[p] = x_dir_s[p];
`endif
            end
        end
    end

    // Per-port lock FSM and output-register next state; only an accepted flit moves anything.
    always_comb begin
        data_d  = data_q;
        dir_d   = dir_q;
        valid_d = valid_q & ~ready_in;
        err_d   = 5'b00000;
        for (int p = 0; p < 5; p++) begin
            state_d[p]    = state_q[p];
            lock_dir_d[p] = lock_dir_q[p];
            if (accept_s[p]) begin
                data_d[p*DATASIZE +: DATASIZE] = data_in[p*DATASIZE +: DATASIZE];
                valid_d[p] = 1'b1;
                case (ftype_s[p])
                    T_HEAD: begin
                        dir_d[p*5 +: 5] = rt_dir_s[p];
                        err_d[p]        = rt_err_s[p] | (state_q[p] == S_LOCKED);
                        state_d[p]      = S_LOCKED;
                        lock_dir_d[p]   = rt_dir_s[p];
                    end
                    T_SINGLE: begin
                        dir_d[p*5 +: 5] = rt_dir_s[p];
                        err_d[p]        = rt_err_s[p] | (state_q[p] == S_LOCKED);
                        state_d[p]      = S_IDLE;
                    end
                    T_BODY, T_TAIL: begin
                        if (state_q[p] == S_LOCKED) begin
                            dir_d[p*5 +: 5] = lock_dir_q[p];
                            state_d[p]      = (ftype_s[p] == T_TAIL) ? S_IDLE : S_LOCKED;
                        end else begin
                            dir_d[p*5 +: 5] = DIR_L;
                            err_d[p]        = 1'b1;
                        end
                    end
                    default: begin
                        dir_d[p*5 +: 5] = DIR_L;
                        err_d[p]        = 1'b1;
                    end
                endcase
            end else begin
                state_d[p] = state_q[p];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge rc_clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= {(5*DATASIZE){1'b0}};
            dir_q   <= 25'd0;
            valid_q <= 5'b00000;
            err_q   <= 5'b00000;
            for (int p = 0; p < 5; p++) begin
                state_q[p]    <= S_IDLE;
                lock_dir_q[p] <= 5'b00000;
            end
        end else begin
            data_q  <= data_d;
            dir_q   <= dir_d;
            valid_q <= valid_d;
            err_q   <= err_d;
            for (int p = 0; p < 5; p++) begin
                state_q[p]    <= state_d[p];
                lock_dir_q[p] <= lock_dir_d[p];
            end
        end
    end

endmodule
